// File: rtl/vga_char_buf_scan_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_char_buf_pkg
// Description : Shared constants, frame-size helper and scan FSM states for
//               the character-buffer scan reader.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_char_buf_pkg;

    localparam int c_BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Number of 32-bit SRAM words holding one full frame of characters
    function automatic int nwords(input int cols, input int rows);
        return (cols * rows) / c_BYTES_PER_WORD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_char_buf_scan_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_char_buf_scan_reader_if
// Description : SRAM port-2 read bus plus Avalon-ST character stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_char_buf_scan_reader_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] address2;
    logic              chipselect2;
    logic [31:0]       readdata2;
    logic [7:0]        stream_data;
    logic              stream_valid;
    logic              stream_ready;
    logic              stream_startofpacket;
    logic              stream_endofpacket;

    modport master (
        output address2, chipselect2,
        input  readdata2,
        output stream_data, stream_valid, stream_startofpacket, stream_endofpacket,
        input  stream_ready
    );

    modport slave (
        input  address2, chipselect2,
        output readdata2,
        input  stream_data, stream_valid, stream_startofpacket, stream_endofpacket,
        output stream_ready
    );
endinterface
`default_nettype wire

// File: rtl/vga_char_buf_scan_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : char_word_fifo
// Description : 2-deep synchronous FIFO holding SRAM words awaiting
//               serialisation; head is visible combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module char_word_fifo #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [1:0]            o_count,
    output logic [WIDTH-1:0]      o_head
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is only legal when the head leaves this cycle
    assign w_do_push = i_push && ((r_count != 2'd2) || i_pop);
    assign w_do_pop  = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

endmodule
`default_nettype wire

// File: rtl/vga_char_buf_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : vga_char_buf_scan_reader
// Description : Reads the character buffer from SRAM port 2 in raster order
//               and emits it as a framed 8-bit Avalon-ST stream.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_char_buf_scan_reader
    import vga_char_buf_pkg::*;
#(
    parameter int COLS      = 80,
    parameter int ROWS      = 60,
    parameter int ADDR_W    = 11,
    parameter int BASE_WORD = 0
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic enable,
    output logic      busy,
    vga_char_buf_scan_reader_if.master bus
);

    localparam int c_NWORDS = nwords(COLS, ROWS);
    localparam int c_CNT_W  = ADDR_W + 1;
    localparam int c_FIFO_W = 32 + c_CNT_W;
    localparam logic [c_CNT_W-1:0] c_LAST_WORD = c_CNT_W'(c_NWORDS - 1);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_word_cnt;
    logic                 r_inflight;
    logic [c_CNT_W-1:0]   r_inflight_tag;
    logic [1:0]           r_byte_idx;
    logic                 r_busy;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [1:0]           w_fifo_count;
    logic [c_FIFO_W-1:0]  w_fifo_head;
    logic [c_CNT_W-1:0]   w_head_tag;
    logic [31:0]          w_head_word;
    logic [1:0]           w_pending;
    logic                 w_issue;
    logic                 w_valid;
    logic                 w_beat;
    logic                 w_pop;
    logic                 w_sop;
    logic                 w_eop;
    logic [7:0]           w_byte;

    // Words buffered plus the read whose data lands this cycle bound the issue
    assign w_pending = w_fifo_count + {1'b0, r_inflight};
    assign w_issue   = (r_state == SCAN) && !w_fifo_full && (w_pending < 2'd2);

    assign w_head_tag  = w_fifo_head[c_FIFO_W-1:32];
    assign w_head_word = w_fifo_head[31:0];
    assign w_valid     = !w_fifo_empty;
    assign w_beat      = w_valid && bus.stream_ready;
    assign w_pop       = w_beat && (r_byte_idx == 2'd3);
    assign w_sop       = w_valid && (w_head_tag == '0) && (r_byte_idx == 2'd0);
    assign w_eop       = w_valid && (w_head_tag == c_LAST_WORD) && (r_byte_idx == 2'd3);

    always_comb begin
        w_byte = 8'd0;
        case (r_byte_idx)
            2'd0: w_byte = w_head_word[7:0];
            2'd1: w_byte = w_head_word[15:8];
            2'd2: w_byte = w_head_word[23:16];
            2'd3: w_byte = w_head_word[31:24];
            default: w_byte = 8'd0;
        endcase
    end

    char_word_fifo #(
        .WIDTH (c_FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_tag, bus.readdata2}),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count),
        .o_head  (w_fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_word_cnt     <= '0;
            r_inflight     <= 1'b0;
            r_inflight_tag <= '0;
            r_byte_idx     <= 2'd0;
            r_busy         <= 1'b0;
        end else begin
            r_inflight     <= w_issue;
            r_inflight_tag <= r_word_cnt;
            if (w_beat) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state    <= SCAN;
                        r_word_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                SCAN: begin
                    if (w_issue) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (r_word_cnt == c_LAST_WORD) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_beat && w_eop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.address2             = ADDR_W'(BASE_WORD) + r_word_cnt[ADDR_W-1:0];
    assign bus.chipselect2          = w_issue;
    assign bus.stream_valid         = w_valid;
    assign bus.stream_data          = w_valid ? w_byte : 8'd0;
    assign bus.stream_startofpacket = w_sop;
    assign bus.stream_endofpacket   = w_eop;
    assign busy                     = r_busy;

endmodule
`default_nettype wire

// File: doc/vga_char_buf_scan_reader.md
Name: vga_char_buf_scan_reader

Overview:
Streams the character buffer out of the dual-port on-chip SRAM's second port (32-bit words, 4 characters per word) in raster order. Its output is an Avalon-ST 8-bit character stream with packet framing, one packet per frame. The consumer is the downstream character-to-pixel renderer. The block issues pipelined reads against the SRAM's 1-cycle read latency and absorbs output backpressure with a 2-word buffer.

Parameters:
COLS, 80, characters per row; must be a multiple of 4
ROWS, 60, rows per frame
ADDR_W, 11, SRAM word-address width; COLS*ROWS/4 must be <= 2**ADDR_W
BASE_WORD, 0, first SRAM word address of the frame

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scan enable from control register; sampled only at frame boundaries
address2  out  ADDR_W  SRAM port-2 word address
chipselect2  out  1  SRAM port-2 read strobe; write2=0, byteenable2=4'hF and clken2=1 are tied at the top level
readdata2  in  32  SRAM port-2 data; valid in the cycle after chipselect2 is sampled high
stream_data  out  8  character code
stream_valid  out  1  beat valid
stream_ready  in  1  downstream accept
stream_startofpacket  out  1  first character of the frame
stream_endofpacket  out  1  last character of the frame
busy  out  1  frame in progress

Behaviour:
- Reset values: stream_valid=0, stream_startofpacket=0, stream_endofpacket=0, chipselect2=0, busy=0, address2=BASE_WORD, stream_data=0. Reset flushes the FIFO, in-flight tracking and all counters; any SRAM read in flight is ignored.
- Define NWORDS = COLS*ROWS/4 (1200 at defaults).
- FSM states:
  - IDLE: stay until enable=1. Then enter SCAN, set the word counter to 0 and busy=1.
  - SCAN: issue reads. Go to DRAIN once word NWORDS-1 has been issued.
  - DRAIN: wait until the last character is accepted. Then go to IDLE; busy=0 in the cycle after the final handshake.
  - Deasserting enable mid-frame does not abort the frame; it completes. Re-enable is checked in IDLE, so back-to-back frames have a 1-cycle IDLE gap.
- Read issue:
  - In SCAN, assert chipselect2 with address2 = BASE_WORD + word counter when FIFO occupancy plus in-flight reads < 2. Increment the counter on each issue.
  - At most one read is in flight. Data is captured from readdata2 one cycle later into a 2-entry word FIFO, tagged with its word index.
- Serializer:
  - Pops the FIFO head word and presents bytes in little-endian order: byte 0 = bits [7:0] first, through byte 3 = [31:24]. Advance only on stream_valid & stream_ready.
  - stream_data, stream_valid, SOP and EOP hold stable while valid=1 and ready=0.
  - Pop the FIFO on the handshake of byte 3. A new head word may present byte 0 in the next cycle, so there are no bubbles when the FIFO is non-empty.
- Framing: SOP=1 only on byte 0 of word 0. EOP=1 only on byte 3 of word NWORDS-1.
- Throughput: sustained 1 char/cycle under continuous ready. First valid occurs 2 cycles after leaving IDLE: 1 cycle to issue, 1 cycle to capture.
- Simultaneous push and pop on the FIFO in the same cycle is allowed and keeps occupancy unchanged.
- Address arithmetic: ADDR_W bits; the counter is (ADDR_W+1) bits wide to compare against NWORDS without wrap.

Decomposition:
- Package vga_char_buf_pkg holds BYTES_PER_WORD=4, the NWORDS function of COLS/ROWS, and the FSM state enum {IDLE, SCAN, DRAIN}.
- One sub-module: char_word_fifo, a 2-deep x 32-bit synchronous FIFO with push, pop, full, empty and count outputs, reset by the same synchronous reset.

Test Plan:
1. Full frame: SRAM word 0 = 32'h44434241, word 1199 = 32'h5A595857; enable=1 pulse, ready=1 always.
   - First beat is 8'h41 with SOP=1.
   - Beats 2-4 are 8'h42, 8'h43, 8'h44.
   - Beat 4800 is 8'h5A with EOP=1.
   - Exactly 4800 beats arrive, back-to-back after the first.
2. Backpressure: hold ready=0 for 10 cycles mid-word.
   - stream_data, valid and SOP/EOP are stable throughout.
   - No byte is lost or duplicated.
   - chipselect2 is never asserted while FIFO count plus in-flight reads equals 2.
3. Random ready (50%) over a full frame: the received byte sequence matches the SRAM image with BASE_WORD=0; SOP and EOP each appear exactly once.
4. Reset mid-frame: assert reset at beat 100 for 1 cycle.
   - Next cycle: valid=0, busy=0, chipselect2=0.
   - Re-enable: the stream restarts at word 0 with SOP=1.
5. Enable dropped mid-frame at beat 50: the frame still completes to EOP at beat 4800, then the block stays in IDLE (busy=0, no further chipselect2).
6. Small config COLS=8, ROWS=2, BASE_WORD=16: chipselect2 addresses are 16, 17, 18, 19 only; 16 beats arrive, EOP is on beat 16, and 2 frames run back-to-back with enable held high.
